// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: sequencer states, opcodes and IR field positions.
// The optional MUL/DIV sequence is enabled by defining CTRL_MULDIV_EN.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // The ALU-class opcodes form one contiguous range.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/reg_select.sv
// Decodes the selected IR register field (Ra/Rb/Rc) into one-hot Rin/Rout enables.
// Indices at or above NREGS decode to all zeros.
module reg_select
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic [31:0]      ir,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin_req,
  input  logic             rout_req,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout
);

  logic [3:0]       idx;
  logic [NREGS-1:0] onehot;
  logic             unused_ir;

  assign unused_ir = ^{ir[OPC_MSB:OPC_LSB], ir[RC_LSB-1:0]};

  always_comb begin
    idx = '0;
    if (gra)      idx = ir[RA_MSB:RA_LSB];
    else if (grb) idx = ir[RB_MSB:RB_LSB];
    else if (grc) idx = ir[RC_MSB:RC_LSB];

    onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(idx) == i) onehot[i] = 1'b1;
    end

    rin  = rin_req  ? onehot : '0;
    rout = rout_req ? onehot : '0;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore-style hardwired sequencer: fetch in T0-T2, execute in T3-T5 (T6 for MUL/DIV).
// Define CTRL_MULDIV_EN to compile in the MUL/DIV sequence; otherwise those opcodes fault.
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             ZHighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             LOin,
  output logic             HIin,
  output logic             IncPC,
  output logic             Read,
  output logic [4:0]       operation,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Done,
  output logic             Fault,
  output state_t           state
);

  state_t     next_state;
  state_t     final_next;
  logic [4:0] opcode;
  logic       alu_op;
  logic       muldiv_op;
  logic       halt_op;
  logic       gra, grb, grc, rin_req, rout_req;

  assign opcode  = IR[OPC_MSB:OPC_LSB];
  assign alu_op  = is_alu_op(opcode);
  assign halt_op = (opcode == OP_HALT);
`ifdef CTRL_MULDIV_EN
  assign muldiv_op = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
  assign muldiv_op = 1'b0;
`endif
  // Run is only looked at here and in IDLE, so dropping it mid-instruction lets it finish.
  assign final_next = Run ? S_T0 : S_IDLE;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; LOin = 1'b0; HIin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; operation = '0; Done = 1'b0; Fault = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin_req = 1'b0; rout_req = 1'b0;
    case (state)
      S_IDLE: if (Run) next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        if (alu_op) begin
          grb = 1'b1; rout_req = 1'b1; Yin = 1'b1;
          next_state = S_T4;
        end else if (muldiv_op) begin
          gra = 1'b1; rout_req = 1'b1; Yin = 1'b1;
          next_state = S_T4;
        end else if (halt_op) begin
          Done = 1'b1;
          next_state = S_HALT;
        end else begin
          next_state = S_FAULT;
        end
      end
      S_T4: begin
        if (muldiv_op) grb = 1'b1;
        else           grc = 1'b1;
        rout_req = 1'b1; operation = opcode; Zin = 1'b1;
        next_state = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef CTRL_MULDIV_EN
        if (muldiv_op) begin
          LOin = 1'b1;
          next_state = S_T6;
        end else begin
          gra = 1'b1; rin_req = 1'b1; Done = 1'b1;
          next_state = final_next;
        end
`else
        gra = 1'b1; rin_req = 1'b1; Done = 1'b1;
        next_state = final_next;
`endif
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        next_state = final_next;
      end
`endif
      S_HALT:  next_state = S_HALT;
      S_FAULT: begin
        Fault = 1'b1;
        next_state = S_FAULT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  reg_select #(.NREGS(NREGS)) u_reg_select (
    .ir       (IR),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rin_req  (rin_req),
    .rout_req (rout_req),
    .rin      (Rin),
    .rout     (Rout)
  );

  // Only one source may drive the shared bus in any state.
  bus_one_driver: assert property (@(posedge Clock)
    $onehot0({PCout, Zlowout, ZHighout, MDRout, |Rout}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Table-driven bench for ctrl_sequencer: per-cycle vectors plus bounded latency sequences.
// Expectations for MUL follow CTRL_MULDIV_EN.
module tb_ctrl_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int NREGS = 16;

  localparam logic [15:0] M_PCOUT = 16'h8000, M_ZLO   = 16'h4000, M_ZHI   = 16'h2000;
  localparam logic [15:0] M_MDRO  = 16'h1000, M_MARIN = 16'h0800, M_PCIN  = 16'h0400;
  localparam logic [15:0] M_MDRIN = 16'h0200, M_IRIN  = 16'h0100, M_YIN   = 16'h0080;
  localparam logic [15:0] M_ZIN   = 16'h0040, M_LOIN  = 16'h0020, M_HIIN  = 16'h0010;
  localparam logic [15:0] M_INCPC = 16'h0008, M_READ  = 16'h0004, M_DONE  = 16'h0002;
  localparam logic [15:0] M_FAULT = 16'h0001;
  localparam logic [15:0] M_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [15:0] M_T1 = M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [15:0] M_T2 = M_MDRO | M_IRIN;

  localparam logic [31:0] IR_SUB  = 32'h221B_8000;  // SUB R4,R3,R7
  localparam logic [31:0] IR_ADD  = 32'h1891_8000;  // ADD R1,R2,R3
  localparam logic [31:0] IR_MUL  = 32'h7B38_0000;  // MUL R6,R7
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;  // opcode 11111
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  // clock / reset
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset_n, Run;
  logic [31:0] IR;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, LOin, HIin, IncPC, Read, Done, Fault;
  logic [4:0] operation;
  logic [NREGS-1:0] Rin, Rout;
  state_t state;

  ctrl_sequencer #(.NREGS(NREGS)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .Read(Read), .operation(operation),
    .Rin(Rin), .Rout(Rout), .Done(Done), .Fault(Fault), .state(state)
  );

  typedef struct {
    logic        rst_n;
    logic        run;
    logic [31:0] ir;
    state_t      st;
    logic [15:0] strb;
    logic [4:0]  op;
    logic [15:0] rin;
    logic [15:0] rout;
    string       tag;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic add(input logic rst_n, input logic run, input logic [31:0] ir,
                     input state_t st, input logic [15:0] strb, input logic [4:0] op,
                     input logic [15:0] rin, input logic [15:0] rout, input string tag);
    vec_t v;
    v.rst_n = rst_n; v.run = run; v.ir = ir; v.st = st; v.strb = strb;
    v.op = op; v.rin = rin; v.rout = rout; v.tag = tag;
    vq.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] ir, input string tag);
    add(1, 1, ir, S_T0, M_T0, 5'd0, 16'h0, 16'h0, {tag, "_t0"});
    add(1, 1, ir, S_T1, M_T1, 5'd0, 16'h0, 16'h0, {tag, "_t1"});
    add(1, 1, ir, S_T2, M_T2, 5'd0, 16'h0, 16'h0, {tag, "_t2"});
  endtask

  // scoreboard compare of one applied vector
  task automatic check_vec(input vec_t v);
    logic [15:0] strb_act;
    strb_act = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, Zin, LOin, HIin, IncPC, Read, Done, Fault};
    n_vec++;
    if (state !== v.st || strb_act !== v.strb || operation !== v.op ||
        Rin !== v.rin || Rout !== v.rout) begin
      n_bad++;
      $display("FAIL %s: got state=%0d strb=%h op=%h rin=%h rout=%h, want state=%0d strb=%h op=%h rin=%h rout=%h",
               v.tag, state, strb_act, operation, Rin, Rout, v.st, v.strb, v.op, v.rin, v.rout);
    end
  endtask

  // bounded wait for Done after a fresh start; cnt counts edges from Run seen in IDLE
  task automatic measure(input logic [31:0] ir, input int exp_cycles, input string tag);
    int cnt;
    logic seen;
    Reset_n = 1'b0; Run = 1'b0; IR = ir;
    @(posedge Clock); #1;
    Reset_n = 1'b1; Run = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 30) begin
      @(posedge Clock); #1;
      cnt++;
      if (Done) seen = 1'b1;
    end
    Run = 1'b0;
    n_vec++;
    if (!seen || cnt != exp_cycles) begin
      n_bad++;
      $display("FAIL %s: done_seen=%0b cycles=%0d, want done at cycle %0d", tag, seen, cnt, exp_cycles);
    end
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b0; IR = '0;

    // reset and SUB R4,R3,R7
    add(0, 0, 32'h0, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "reset");
    fetch(IR_SUB, "sub");
    add(1, 1, IR_SUB, S_T3, M_YIN,          5'd0,     16'h0,    16'h0008, "sub_t3");
    add(1, 1, IR_SUB, S_T4, M_ZIN,          5'b00100, 16'h0,    16'h0080, "sub_t4");
    add(1, 1, IR_SUB, S_T5, M_ZLO | M_DONE, 5'd0,     16'h0010, 16'h0,    "sub_t5");

    // two ADDs back to back, Run dropped during the second T4
    fetch(IR_ADD, "add1");
    add(1, 1, IR_ADD, S_T3, M_YIN,          5'd0,     16'h0,    16'h0004, "add1_t3");
    add(1, 1, IR_ADD, S_T4, M_ZIN,          5'b00011, 16'h0,    16'h0008, "add1_t4");
    add(1, 1, IR_ADD, S_T5, M_ZLO | M_DONE, 5'd0,     16'h0002, 16'h0,    "add1_t5");
    fetch(IR_ADD, "add2");
    add(1, 1, IR_ADD, S_T3, M_YIN,          5'd0,     16'h0,    16'h0004, "add2_t3");
    add(1, 1, IR_ADD, S_T4, M_ZIN,          5'b00011, 16'h0,    16'h0008, "add2_t4");
    add(1, 0, IR_ADD, S_T5, M_ZLO | M_DONE, 5'd0,     16'h0002, 16'h0,    "add2_t5");
    add(1, 0, IR_ADD, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "add2_idle");
    add(1, 0, IR_ADD, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "idle_hold");

    // reset during T4, then restart
    fetch(IR_SUB, "rst");
    add(1, 1, IR_SUB, S_T3, M_YIN, 5'd0,     16'h0, 16'h0008, "rst_t3");
    add(1, 1, IR_SUB, S_T4, M_ZIN, 5'b00100, 16'h0, 16'h0080, "rst_t4");
    add(0, 1, IR_SUB, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "rst_mid");
    add(0, 1, IR_SUB, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "rst_hold");
    fetch(IR_SUB, "restart");
    add(1, 1, IR_SUB, S_T3, M_YIN,          5'd0,     16'h0,    16'h0008, "restart_t3");
    add(1, 1, IR_SUB, S_T4, M_ZIN,          5'b00100, 16'h0,    16'h0080, "restart_t4");
    add(1, 0, IR_SUB, S_T5, M_ZLO | M_DONE, 5'd0,     16'h0010, 16'h0,    "restart_t5");
    add(1, 0, IR_SUB, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "restart_idle");

    // MUL R6,R7
    fetch(IR_MUL, "mul");
`ifdef CTRL_MULDIV_EN
    add(1, 1, IR_MUL, S_T3, M_YIN,                   5'd0,     16'h0, 16'h0040, "mul_t3");
    add(1, 1, IR_MUL, S_T4, M_ZIN,                   5'b01111, 16'h0, 16'h0080, "mul_t4");
    add(1, 1, IR_MUL, S_T5, M_ZLO | M_LOIN,          5'd0,     16'h0, 16'h0,    "mul_t5");
    add(1, 0, IR_MUL, S_T6, M_ZHI | M_HIIN | M_DONE, 5'd0,     16'h0, 16'h0,    "mul_t6");
    add(1, 0, IR_MUL, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "mul_idle");
`else
    add(1, 1, IR_MUL, S_T3,    16'h0,   5'd0, 16'h0, 16'h0, "mul_t3");
    add(1, 1, IR_MUL, S_FAULT, M_FAULT, 5'd0, 16'h0, 16'h0, "mul_fault");
    add(0, 0, IR_MUL, S_IDLE,  16'h0,   5'd0, 16'h0, 16'h0, "mul_rst");
`endif

    // illegal opcode: sticky FAULT until reset
    fetch(IR_ILL, "ill");
    add(1, 1, IR_ILL, S_T3, 16'h0, 5'd0, 16'h0, 16'h0, "ill_t3");
    for (int i = 0; i < 4; i++)
      add(1, (i % 2 == 0), IR_ILL, S_FAULT, M_FAULT, 5'd0, 16'h0, 16'h0, "ill_fault");
    add(0, 1, IR_ILL, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "ill_rst");
    add(1, 0, IR_ILL, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "ill_idle");

    // HALT: Done in T3, then held regardless of Run
    fetch(IR_HALT, "halt");
    add(1, 1, IR_HALT, S_T3, M_DONE, 5'd0, 16'h0, 16'h0, "halt_t3");
    for (int i = 0; i < 20; i++)
      add(1, (i % 3 != 0), IR_HALT, S_HALT, 16'h0, 5'd0, 16'h0, 16'h0, "halt_hold");
    add(0, 0, IR_HALT, S_IDLE, 16'h0, 5'd0, 16'h0, 16'h0, "halt_rst");

    foreach (vq[i]) begin
      Reset_n = vq[i].rst_n;
      Run     = vq[i].run;
      IR      = vq[i].ir;
      @(posedge Clock); #1;
      check_vec(vq[i]);
    end

    // multi-cycle latency checks
    measure(IR_SUB,  6, "lat_sub");
    measure(IR_ADD,  6, "lat_add");
    measure(IR_HALT, 4, "lat_halt");
`ifdef CTRL_MULDIV_EN
    measure(IR_MUL,  7, "lat_mul");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
